mem_port_arbiter: RTL and testbench

//  Shares one SRAM-like memory port between instruction fetch (IF) and data access (MEM) masters.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/arb_owner_fifo.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared owner ids, FSM states and size encodings for the memory port arbiter
package mem_port_arbiter_pkg;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD_I = 2'd1;
  localparam logic [1:0] ST_HOLD_D = 2'd2;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/arb_owner_fifo.sv
// rtl/arb_owner_fifo.sv - 1-bit owner-id FIFO tracking which master each outstanding request belongs to
module arb_owner_fifo #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  // A full FIFO refuses push even when a pop frees a slot in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between IF and MEM, data priority, in-order response routing
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  output logic        err_unexp_ok
);

  logic [1:0] state_q, state_d;
  logic       err_q, err_d;
  logic       sel_data, sel_req;
  logic       accept, pop, fifo_full, fifo_empty, fifo_head, resp_valid;

  // Held states pin the master so a rising data_req cannot preempt a pending inst request.
  always_comb begin
    sel_data = 1'b0;
    sel_req  = 1'b0;
    case (state_q)
      ST_HOLD_I: begin
        sel_data = 1'b0;
        sel_req  = inst_req;
      end
      ST_HOLD_D: begin
        sel_data = 1'b1;
        sel_req  = data_req;
      end
      default: begin
        sel_data = data_req;
        sel_req  = data_req | inst_req;
      end
    endcase
  end

  assign s_req   = sel_req & ~fifo_full;
  assign s_wr    = sel_data ? data_wr    : 1'b0;
  assign s_size  = sel_data ? data_size  : SIZE_WORD;
  assign s_addr  = sel_data ? data_addr  : inst_addr;
  assign s_wstrb = sel_data ? data_wstrb : 4'h0;
  assign s_wdata = sel_data ? data_wdata : 32'h0;

  assign accept       = s_req & s_addr_ok & ~reset;
  assign inst_addr_ok = accept & ~sel_data;
  assign data_addr_ok = accept & sel_data;

  assign pop          = s_data_ok & ~reset;
  assign resp_valid   = pop & ~fifo_empty;
  assign inst_data_ok = resp_valid & (fifo_head == OWN_I);
  assign data_data_ok = resp_valid & (fifo_head == OWN_D);
  assign inst_rdata   = s_rdata;
  assign data_rdata   = s_rdata;
  assign err_unexp_ok = err_q;

  always_comb begin
    state_d = state_q;
    err_d   = err_q | (pop & fifo_empty);
    case (state_q)
      ST_IDLE: begin
        if (s_req && !s_addr_ok) begin
          state_d = sel_data ? ST_HOLD_D : ST_HOLD_I;
        end
      end
      ST_HOLD_I, ST_HOLD_D: begin
        if (accept) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  arb_owner_fifo #(
    .DEPTH (MAX_OUTST),
    .CNT_W (CNT_W)
  ) u_owner_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .push_id (sel_data ? OWN_D : OWN_I),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr;
  logic [3:0]  s_wstrb;
  logic [31:0] s_wdata;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;
  logic        err_unexp_ok;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_OUTST(2), .CNT_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .s_req        (s_req),
    .s_wr         (s_wr),
    .s_size       (s_size),
    .s_addr       (s_addr),
    .s_wstrb      (s_wstrb),
    .s_wdata      (s_wdata),
    .s_addr_ok    (s_addr_ok),
    .s_data_ok    (s_data_ok),
    .s_rdata      (s_rdata),
    .err_unexp_ok (err_unexp_ok)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    inst_req   = 1'b0;
    inst_addr  = 32'h0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'd2;
    data_addr  = 32'h0;
    data_wstrb = 4'h0;
    data_wdata = 32'h0;
    s_addr_ok  = 1'b0;
    s_data_ok  = 1'b0;
    s_rdata    = 32'h0;
  endtask

  // Each step: change inputs on the falling edge, settle, then check combinational outputs.
  task automatic step();
    @(negedge clk);
    quiet();
  endtask

  initial begin
    reset = 1'b1;
    quiet();
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h1c000000; s_addr_ok = 1'b1; s_data_ok = 1'b1;
    #1;
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_data_addr_ok", data_addr_ok, 0);
    chk("rst_inst_data_ok", inst_data_ok, 0);
    chk("rst_data_data_ok", data_data_ok, 0);
    step(); reset = 1'b0; #1;
    chk("rst_err", err_unexp_ok, 0);
    chk("rst_s_req", s_req, 0);

    // 1: lone inst fetch, response two cycles later
    step(); inst_req = 1'b1; inst_addr = 32'h1c000000; s_addr_ok = 1'b1; #1;
    chk("t1_s_req", s_req, 1);
    chk("t1_s_addr", s_addr, 32'h1c000000);
    chk("t1_s_wr", s_wr, 0);
    chk("t1_s_size", s_size, 2);
    chk("t1_s_wstrb", s_wstrb, 0);
    chk("t1_inst_addr_ok", inst_addr_ok, 1);
    chk("t1_data_addr_ok", data_addr_ok, 0);
    step(); #1;
    chk("t1_idle_s_req", s_req, 0);
    step(); s_data_ok = 1'b1; s_rdata = 32'h1234; #1;
    chk("t1_inst_data_ok", inst_data_ok, 1);
    chk("t1_inst_rdata", inst_rdata, 32'h1234);
    chk("t1_data_data_ok", data_data_ok, 0);

    // 2: simultaneous requests, data wins
    step();
    inst_req = 1'b1; inst_addr = 32'h2000;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h100; data_wstrb = 4'hf; data_wdata = 32'hdeadbeef;
    s_addr_ok = 1'b1; #1;
    chk("t2_s_addr", s_addr, 32'h100);
    chk("t2_s_wr", s_wr, 1);
    chk("t2_s_wstrb", s_wstrb, 4'hf);
    chk("t2_s_wdata", s_wdata, 32'hdeadbeef);
    chk("t2_data_addr_ok", data_addr_ok, 1);
    chk("t2_inst_addr_ok", inst_addr_ok, 0);
    step(); inst_req = 1'b1; inst_addr = 32'h2000; s_addr_ok = 1'b1; #1;
    chk("t2_next_s_addr", s_addr, 32'h2000);
    chk("t2_next_s_wdata", s_wdata, 0);
    chk("t2_next_inst_addr_ok", inst_addr_ok, 1);
    step(); s_data_ok = 1'b1; s_rdata = 32'haa; #1;
    chk("t2_resp1_data_ok", data_data_ok, 1);
    chk("t2_resp1_inst_ok", inst_data_ok, 0);
    chk("t2_resp1_rdata", data_rdata, 32'haa);
    step(); s_data_ok = 1'b1; s_rdata = 32'hbb; #1;
    chk("t2_resp2_inst_ok", inst_data_ok, 1);
    chk("t2_resp2_data_ok", data_data_ok, 0);
    chk("t2_resp2_rdata", inst_rdata, 32'hbb);

    // 3: inst held through three refused cycles, no preemption
    step(); inst_req = 1'b1; inst_addr = 32'h3000; #1;
    chk("t3_c0_s_addr", s_addr, 32'h3000);
    chk("t3_c0_inst_addr_ok", inst_addr_ok, 0);
    for (int c = 1; c < 3; c++) begin
      step(); inst_req = 1'b1; inst_addr = 32'h3000; data_req = 1'b1; data_addr = 32'h400; #1;
      chk("t3_hold_s_addr", s_addr, 32'h3000);
      chk("t3_hold_s_wr", s_wr, 0);
      chk("t3_hold_data_addr_ok", data_addr_ok, 0);
    end
    step(); inst_req = 1'b1; inst_addr = 32'h3000; data_req = 1'b1; data_addr = 32'h400; s_addr_ok = 1'b1; #1;
    chk("t3_acc_s_addr", s_addr, 32'h3000);
    chk("t3_acc_inst_addr_ok", inst_addr_ok, 1);
    chk("t3_acc_data_addr_ok", data_addr_ok, 0);
    step(); data_req = 1'b1; data_addr = 32'h400; s_addr_ok = 1'b1; #1;
    chk("t3_data_s_addr", s_addr, 32'h400);
    chk("t3_data_addr_ok", data_addr_ok, 1);

    // 4: two outstanding (I then D) -> issue blocked, pop+push same cycle still blocked
    step(); data_req = 1'b1; data_addr = 32'h500; s_addr_ok = 1'b1; #1;
    chk("t4_full_s_req", s_req, 0);
    chk("t4_full_data_addr_ok", data_addr_ok, 0);
    step(); data_req = 1'b1; data_addr = 32'h500; s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'h11; #1;
    chk("t4_pop_s_req", s_req, 0);
    chk("t4_pop_inst_data_ok", inst_data_ok, 1);
    chk("t4_pop_data_data_ok", data_data_ok, 0);
    step(); data_req = 1'b1; data_addr = 32'h500; s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'h22; #1;
    chk("t4_resume_s_req", s_req, 1);
    chk("t4_resume_data_addr_ok", data_addr_ok, 1);
    chk("t4_resume_data_data_ok", data_data_ok, 1);
    chk("t4_resume_inst_data_ok", inst_data_ok, 0);
    chk("t4_resume_rdata", data_rdata, 32'h22);
    step(); s_data_ok = 1'b1; s_rdata = 32'h33; #1;
    chk("t4_last_data_data_ok", data_data_ok, 1);
    chk("t4_err_clear", err_unexp_ok, 0);

    // 5: accept and response together with empty FIFO -> unexpected
    step(); inst_req = 1'b1; inst_addr = 32'h700; s_addr_ok = 1'b1; s_data_ok = 1'b1; #1;
    chk("t5_inst_addr_ok", inst_addr_ok, 1);
    chk("t5_inst_data_ok", inst_data_ok, 0);
    chk("t5_data_data_ok", data_data_ok, 0);
    step(); s_data_ok = 1'b1; s_rdata = 32'h55; #1;
    chk("t5_err_set", err_unexp_ok, 1);
    chk("t5_real_inst_data_ok", inst_data_ok, 1);
    step(); step(); #1;
    chk("t5_err_sticky", err_unexp_ok, 1);

    // 6: reset with two outstanding discards ownership
    step(); inst_req = 1'b1; inst_addr = 32'h800; s_addr_ok = 1'b1; #1;
    chk("t6_acc1", inst_addr_ok, 1);
    step(); data_req = 1'b1; data_addr = 32'h900; s_addr_ok = 1'b1; #1;
    chk("t6_acc2", data_addr_ok, 1);
    step(); reset = 1'b1; inst_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1; #1;
    chk("t6_rst_inst_addr_ok", inst_addr_ok, 0);
    chk("t6_rst_inst_data_ok", inst_data_ok, 0);
    chk("t6_rst_data_data_ok", data_data_ok, 0);
    step(); reset = 1'b0;
    inst_req = 1'b1; inst_addr = 32'ha00; data_req = 1'b1; data_addr = 32'h600; s_addr_ok = 1'b1; #1;
    chk("t6_err_cleared", err_unexp_ok, 0);
    chk("t6_idle_sel_data", s_addr, 32'h600);
    chk("t6_idle_data_addr_ok", data_addr_ok, 1);
    step(); s_data_ok = 1'b1; s_rdata = 32'h44; #1;
    chk("t6_head_is_data", data_data_ok, 1);
    chk("t6_head_not_inst", inst_data_ok, 0);
    step(); s_data_ok = 1'b1; #1;
    chk("t6_unexp_inst", inst_data_ok, 0);
    chk("t6_unexp_data", data_data_ok, 0);
    step(); #1;
    chk("t6_err_set", err_unexp_ok, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
